wb_cmd_initiator: RTL and testbench
===================================

Name: wb_cmd_initiator

Overview:
- Wishbone B4 pipelined initiator that drives the system's Wishbone peripheral port (RAM and register access) from a byte-serial command stream.
- Sits between the SPI byte receiver (MCU link) and the system block.
- Parses command frames, issues single read/write transactions honouring stall/ack, auto-increments the address, and returns read bytes to the SPI transmitter.

Parameters:
- WB_ADDR_WIDTH, 20 (common_pkg): Wishbone address width.
- DATA_WIDTH, 8 (common_pkg): data bus width.
- ACK_TIMEOUT, 63: wb_clock_i cycles to wait for ack after strobe is accepted before aborting.

Ports:
- wb_clock_i  in  1  system clock.
- wb_reset_n_i  in  1  asynchronous, active-low reset.
- rx_start_i  in  1  one-cycle pulse at frame start (chip select asserted).
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle pulse; rx_data_i is valid.
- rd_data_o  out  8  byte read from Wishbone.
- rd_valid_o  out  1  one-cycle pulse; rd_data_o is valid.
- busy_o  out  1  high while a Wishbone transaction is in flight.
- err_o  out  1  sticky error flag; cleared by rx_start_i.
- wb_addr_o  out  WB_ADDR_WIDTH  Wishbone address.
- wb_data_o  out  8  write data.
- wb_data_i  in  8  read data.
- wb_we_o  out  1  write enable.
- wb_cycle_o  out  1  cycle.
- wb_strobe_o  out  1  strobe.
- wb_stall_i  in  1  stall.
- wb_ack_i  in  1  acknowledge.

Behaviour:
- Reset (async, wb_reset_n_i=0):
  - All outputs 0.
  - State CMD.
  - Address register 0.
  - Pending-start flag 0.
- Command byte layout:
  - [7:6] opcode: 00 WRITE_AT, 01 READ_AT, 10 WRITE_NEXT, 11 READ_NEXT.
  - [5:4] must be 00; any other value is invalid.
  - [3:0] address bits A19..A16, used by *_AT only.
- Frame byte sequence:
  - WRITE_AT: cmd, A15..8, A7..0, data.
  - READ_AT: cmd, A15..8, A7..0.
  - WRITE_NEXT: cmd, data.
  - READ_NEXT: cmd only.
- FSM states: CMD, ADDR_HI, ADDR_LO, DATA, REQ, WAIT_ACK, DISCARD. Bytes are consumed only in CMD/ADDR_HI/ADDR_LO/DATA.
- CMD:
  - On rx_valid_i, latch the opcode.
  - *_AT: load A19..16, go to ADDR_HI.
  - WRITE_NEXT: go to DATA.
  - READ_NEXT: go to REQ.
  - Invalid command byte: set err_o, go to DISCARD.
- ADDR_HI then ADDR_LO: load address bytes. After ADDR_LO, WRITE_AT goes to DATA; READ_AT goes to REQ.
- DATA: latch wb_data_o, go to REQ.
- REQ:
  - Entered the cycle after the last frame byte. wb_cycle_o, wb_strobe_o and busy_o go high on that next clock (1-cycle latency).
  - wb_we_o = write opcode.
  - Hold all outputs until a cycle with wb_stall_i=0. On that edge drop wb_strobe_o, keep wb_cycle_o, go to WAIT_ACK.
  - If wb_stall_i is already 0 in the first REQ cycle, strobe is a single cycle.
- WAIT_ACK:
  - On wb_ack_i: drop wb_cycle_o and busy_o.
  - Read: capture wb_data_i into rd_data_o and pulse rd_valid_o on the following cycle.
  - Address += 1, modulo 2^WB_ADDR_WIDTH (0xFFFFF wraps to 0x00000).
  - Return to CMD.
  - Ack arriving in the same cycle the strobe is accepted is legal; handle it identically.
- Timeout:
  - Counter starts on strobe acceptance.
  - After ACK_TIMEOUT cycles without ack: drop wb_cycle_o, set err_o, go to CMD, no rd_valid_o, address unchanged.
  - The stall phase has no timeout.
- *_NEXT opcodes use the current address register. After reset that value is 0.
- Byte arriving while in REQ/WAIT_ACK (overrun): byte dropped, err_o set, transaction unaffected.
- DISCARD: ignore all bytes until rx_start_i.
- rx_start_i:
  - In CMD/ADDR_*/DATA/DISCARD: go to CMD, clear err_o. The address register is retained.
  - In REQ/WAIT_ACK: set pending-start. The in-flight transaction completes normally (no cycle abandonment), then pending-start is applied (err_o cleared after any timeout error from that transaction).
- rx_start_i and rx_valid_i in the same cycle: the start is processed first, and the byte is treated as the new command byte.
- wb_addr_o/wb_data_o/wb_we_o are stable from the first REQ cycle until ack or abort. Outside a cycle they hold their last values.

Decomposition:
- common_pkg: WB_ADDR_WIDTH, DATA_WIDTH, opcode enum (CMD_WRITE_AT, CMD_READ_AT, CMD_WRITE_NEXT, CMD_READ_NEXT), and the FSM state typedef.
- One sub-module is natural: wb_txn, the REQ/WAIT_ACK engine with timeout counter (start pulse, we/addr/data in; done/timeout/rdata out). The parser stays in the top level.

Test Plan:
- WRITE_AT: bytes 0x01,0x23,0x45,0xA5; stall=0, ack 2 cycles after strobe -> one WB write, addr 0x12345, data 0xA5, strobe 1 cycle, cycle 3 cycles; next-address register 0x12346.
- READ_AT then READ_NEXT: 0x40,0x80,0x00 with wb_data_i=0x3C, then frame 0xC0 with wb_data_i=0x7E -> rd_valid_o pulses with 0x3C (addr 0x08000), then 0x7E (addr 0x08001).
- Stall then wrap:
  - Address 0xFFFFF is set by READ_AT 0x4F,0xFF,0xFF.
  - That frame is issued with wb_stall_i=1 for 5 cycles -> strobe held 6 cycles with outputs stable.
  - A following READ_NEXT addresses 0x00000.
- Timeout: WRITE_NEXT 0x80,0x11, never ack -> wb_cycle_o drops exactly ACK_TIMEOUT=63 cycles after strobe acceptance; err_o=1; no rd_valid_o; address unchanged; rx_start_i clears err_o.
- Overrun plus mid-transaction start: byte 0x55 and rx_start_i arrive during WAIT_ACK -> transaction completes on ack; 0x55 dropped, setting err_o. The pending start is applied on completion, clearing err_o. The next command byte 0x80 is parsed as WRITE_NEXT.
- Invalid and async reset:
  - Command 0x30 -> err_o=1; following bytes are ignored until rx_start_i.
  - Asserting wb_reset_n_i low during REQ immediately clears wb_cycle_o/wb_strobe_o/busy_o.

Source files
------------

// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Package : common_pkg
// Shared bus widths, command opcodes and parser states for wb_cmd_initiator.
// Rev     : 1.0  initial release
// ============================================================================
package common_pkg;

  localparam int WB_ADDR_WIDTH = 20;
  localparam int DATA_WIDTH    = 8;

  typedef enum logic [1:0] {
    CMD_WRITE_AT   = 2'b00,
    CMD_READ_AT    = 2'b01,
    CMD_WRITE_NEXT = 2'b10,
    CMD_READ_NEXT  = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_CMD      = 3'd0,
    ST_ADDR_HI  = 3'd1,
    ST_ADDR_LO  = 3'd2,
    ST_DATA     = 3'd3,
    ST_REQ      = 3'd4,
    ST_WAIT_ACK = 3'd5,
    ST_DISCARD  = 3'd6
  } state_e;

  function automatic logic is_write(input opcode_e op);
    return ~op[0];
  endfunction

  // Bits [5:4] of a command byte are reserved and must be zero.
  function automatic logic cmd_valid(input logic [7:0] cmd);
    return (cmd[5:4] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_txn.sv
`default_nettype none
// ============================================================================
// Module : wb_txn
// Single Wishbone B4 pipelined transfer: strobe until not stalled, then
// wait for ack with an abort after ACK_TIMEOUT cycles.
// Rev    : 1.0  initial release
// ============================================================================
module wb_txn
  import common_pkg::*;
#(
  parameter int ACK_TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     we,
  input  logic [WB_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     accept,
  output logic                     done,
  output logic                     timeout,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]    wb_wdata,
  input  logic [DATA_WIDTH-1:0]    wb_rdata,
  output logic                     wb_we,
  output logic                     wb_cyc,
  output logic                     wb_stb,
  input  logic                     wb_stall,
  input  logic                     wb_ack
);

  localparam int c_cnt_w = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 1);

  logic               r_wait;
  logic [c_cnt_w-1:0] r_cnt;

  // Ack is honoured in the acceptance cycle as well as afterwards.
  assign accept  = wb_stb & ~wb_stall;
  assign done    = wb_cyc & wb_ack & (r_wait | accept);
  assign timeout = r_wait & ~wb_ack & (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait   <= 1'b0;
      r_cnt    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wb_addr  <= '0;
      wb_wdata <= '0;
      wb_we    <= 1'b0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (start) begin
        wb_cyc  <= 1'b1;
        wb_stb  <= 1'b1;
        wb_we   <= we;
        wb_addr <= addr;
        r_wait  <= 1'b0;
        if (we) begin
          wb_wdata <= wdata;
        end
      end else if (wb_cyc) begin
        if (accept) begin
          wb_stb <= 1'b0;
          r_wait <= 1'b1;
          r_cnt  <= '0;
        end
        if (done) begin
          wb_cyc <= 1'b0;
          wb_stb <= 1'b0;
          r_wait <= 1'b0;
          if (!wb_we) begin
            rd_data  <= wb_rdata;
            rd_valid <= 1'b1;
          end
        end else if (timeout) begin
          wb_cyc <= 1'b0;
          r_wait <= 1'b0;
        end else if (r_wait) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module : wb_cmd_initiator
// Parses byte-serial command frames and issues single Wishbone transfers.
// Rev    : 1.0  initial release
// ============================================================================
module wb_cmd_initiator
  import common_pkg::*;
#(
  parameter int ACK_TIMEOUT = 63
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_n_i,
  input  logic                     rx_start_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_valid_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o,
  output logic                     rd_valid_o,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i
);

  state_e                   r_state;
  opcode_e                  r_op;
  logic [WB_ADDR_WIDTH-1:0] r_addr;
  logic                     r_err;
  logic                     r_pending;

  logic                     w_parse;
  state_e                   w_eff;
  opcode_e                  w_op;
  logic                     w_start;
  logic                     w_start_we;
  logic [WB_ADDR_WIDTH-1:0] w_start_addr;
  logic                     w_accept;
  logic                     w_done;
  logic                     w_timeout;

  // A start in a byte-accepting state restarts parsing before the same-cycle byte is used.
  always_comb begin
    w_parse      = (r_state != ST_REQ) && (r_state != ST_WAIT_ACK);
    w_eff        = (w_parse && rx_start_i) ? ST_CMD : r_state;
    w_op         = opcode_e'(rx_data_i[7:6]);
    w_start      = 1'b0;
    w_start_we   = 1'b0;
    w_start_addr = r_addr;
    if (w_parse && rx_valid_i) begin
      case (w_eff)
        ST_CMD:     w_start = cmd_valid(rx_data_i) && (w_op == CMD_READ_NEXT);
        ST_ADDR_LO: begin
          if (!is_write(r_op)) begin
            w_start      = 1'b1;
            w_start_addr = {r_addr[WB_ADDR_WIDTH-1:8], rx_data_i};
          end
        end
        ST_DATA: begin
          w_start    = 1'b1;
          w_start_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      r_state   <= ST_CMD;
      r_op      <= CMD_WRITE_AT;
      r_addr    <= '0;
      r_err     <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_parse) begin
      if (rx_start_i) begin
        r_state <= ST_CMD;
        r_err   <= 1'b0;
      end
      if (rx_valid_i) begin
        case (w_eff)
          ST_CMD: begin
            if (!cmd_valid(rx_data_i)) begin
              r_err   <= 1'b1;
              r_state <= ST_DISCARD;
            end else begin
              r_op <= w_op;
              if (w_op == CMD_WRITE_AT || w_op == CMD_READ_AT) begin
                r_addr[WB_ADDR_WIDTH-1 -: 4] <= rx_data_i[3:0];
                r_state <= ST_ADDR_HI;
              end else if (w_op == CMD_WRITE_NEXT) begin
                r_state <= ST_DATA;
              end else begin
                r_state <= ST_REQ;
              end
            end
          end
          ST_ADDR_HI: begin
            r_addr[15:8] <= rx_data_i;
            r_state      <= ST_ADDR_LO;
          end
          ST_ADDR_LO: begin
            r_addr[7:0] <= rx_data_i;
            r_state     <= is_write(r_op) ? ST_DATA : ST_REQ;
          end
          ST_DATA:    r_state <= ST_REQ;
          default:    ;
        endcase
      end
    end else begin
      // Transfer in flight: bytes are overruns and a start is deferred to completion.
      if (rx_valid_i) begin
        r_err <= 1'b1;
      end
      if (rx_start_i) begin
        r_pending <= 1'b1;
      end
      if (w_done || w_timeout) begin
        r_state <= ST_CMD;
        if (w_done) begin
          r_addr <= r_addr + 1'b1;
        end
        if (r_pending || rx_start_i) begin
          r_pending <= 1'b0;
          r_err     <= 1'b0;
        end else if (w_timeout) begin
          r_err <= 1'b1;
        end
      end else if (r_state == ST_REQ && w_accept) begin
        r_state <= ST_WAIT_ACK;
      end
    end
  end

  wb_txn #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_txn (
    .clk      (wb_clock_i),
    .rst_n    (wb_reset_n_i),
    .start    (w_start),
    .we       (w_start_we),
    .addr     (w_start_addr),
    .wdata    (rx_data_i),
    .accept   (w_accept),
    .done     (w_done),
    .timeout  (w_timeout),
    .rd_data  (rd_data_o),
    .rd_valid (rd_valid_o),
    .wb_addr  (wb_addr_o),
    .wb_wdata (wb_data_o),
    .wb_rdata (wb_data_i),
    .wb_we    (wb_we_o),
    .wb_cyc   (wb_cycle_o),
    .wb_stb   (wb_strobe_o),
    .wb_stall (wb_stall_i),
    .wb_ack   (wb_ack_i)
  );

  assign err_o  = r_err;
  assign busy_o = wb_cycle_o;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_cmd_initiator
// Scoreboard bench: frame-level reference model feeds queues, monitor checks.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_cmd_initiator;

  localparam int ACK_TIMEOUT = 63;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_start_i, rx_valid_i;
  logic [7:0]  rx_data_i;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o, busy_o, err_o;
  logic [19:0] wb_addr_o;
  logic [7:0]  wb_data_o, wb_data_i;
  logic        wb_we_o, wb_cycle_o, wb_strobe_o, wb_stall_i, wb_ack_i;

  always #5 clk = ~clk;

  wb_cmd_initiator #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .wb_clock_i   (clk),
    .wb_reset_n_i (rst_n),
    .rx_start_i   (rx_start_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .wb_data_i    (wb_data_i),
    .wb_we_o      (wb_we_o),
    .wb_cycle_o   (wb_cycle_o),
    .wb_strobe_o  (wb_strobe_o),
    .wb_stall_i   (wb_stall_i),
    .wb_ack_i     (wb_ack_i)
  );

  typedef struct {
    logic [19:0] addr;
    logic        we;
    logic [7:0]  data;
    int          stb_len;
    int          cyc_len;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        wb_q[$];
  logic [7:0]  rd_q[$];
  logic [19:0] ref_addr = '0;
  bit          ref_err  = 1'b0;

  int          cfg_stall = 0, cfg_dly = 0;
  bit          cfg_noack = 1'b0;
  logic [7:0]  cfg_rdata = '0;

  // Wishbone target: stalls cfg_stall cycles, acks cfg_dly cycles after acceptance.
  int s_k;
  bit s_act;
  initial begin
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_data_i = '0; s_act = 1'b0; s_k = 0;
    forever begin
      @(posedge clk); #1;
      if (!wb_cycle_o) s_act = 1'b0;
      else if (!s_act && wb_strobe_o) begin s_act = 1'b1; s_k = 0; end
      if (s_act) begin
        wb_stall_i = (s_k < cfg_stall);
        wb_ack_i   = !cfg_noack && (s_k == cfg_stall + cfg_dly);
        wb_data_i  = wb_ack_i ? cfg_rdata : 8'($urandom);
        s_k++;
      end else begin
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_data_i  = 8'($urandom);
      end
    end
  end

  // Monitor: pops expectations on strobe acceptance, read-data pulses and cycle end.
  bit          trk = 0, have_exp = 0, unstable = 0, busy_bad = 0, prev_ackcyc = 0;
  int          stb_n, cyc_n, exp_stb, exp_cyc;
  logic [19:0] s_addr;
  logic        s_we;
  logic [7:0]  s_data, e_rd;
  txn_t        e_tx;

  always @(negedge clk) begin
    if (!rst_n) begin
      trk = 0; prev_ackcyc = 0;
    end else begin
      if (rd_valid_o) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected actual=%02h required=none", rd_data_o);
        end else begin
          e_rd = rd_q.pop_front();
          if (rd_data_o !== e_rd || !prev_ackcyc) begin
            errors++;
            $display("FAIL rd_data actual=%02h after_ack=%0d required=%02h after_ack=1",
                     rd_data_o, prev_ackcyc, e_rd);
          end
        end
      end
      if (wb_cycle_o) begin
        if (!trk) begin
          trk = 1; stb_n = 0; cyc_n = 0; have_exp = 0; unstable = 0; busy_bad = 0;
          s_addr = wb_addr_o; s_we = wb_we_o; s_data = wb_data_o;
        end
        cyc_n++;
        if (wb_strobe_o) stb_n++;
        if (wb_addr_o !== s_addr || wb_we_o !== s_we || wb_data_o !== s_data) unstable = 1;
        if (!busy_o) busy_bad = 1;
        if (wb_strobe_o && !wb_stall_i) begin
          checks++;
          if (wb_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected actual addr=%05h we=%0d required=none", wb_addr_o, wb_we_o);
          end else begin
            e_tx = wb_q.pop_front();
            have_exp = 1; exp_stb = e_tx.stb_len; exp_cyc = e_tx.cyc_len;
            if (wb_addr_o !== e_tx.addr || wb_we_o !== e_tx.we ||
                (e_tx.we && wb_data_o !== e_tx.data)) begin
              errors++;
              $display("FAIL wb_req actual addr=%05h we=%0d data=%02h required addr=%05h we=%0d data=%02h",
                       wb_addr_o, wb_we_o, wb_data_o, e_tx.addr, e_tx.we, e_tx.data);
            end
          end
        end
      end else if (trk) begin
        trk = 0;
        checks++;
        if (!have_exp || stb_n != exp_stb || cyc_n != exp_cyc || unstable || busy_bad) begin
          errors++;
          $display("FAIL wb_cycle actual stb=%0d cyc=%0d unstable=%0d busy_bad=%0d required stb=%0d cyc=%0d",
                   stb_n, cyc_n, unstable, busy_bad, exp_stb, exp_cyc);
        end
      end
      prev_ackcyc = wb_cycle_o && wb_ack_i;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit st);
    rx_data_i = b; rx_valid_i = 1'b1; rx_start_i = st;
    @(posedge clk); #1;
    rx_valid_i = 1'b0; rx_start_i = 1'b0;
  endtask

  task automatic pulse_start();
    rx_start_i = 1'b1;
    @(posedge clk); #1;
    rx_start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 300) begin @(posedge clk); #1; n++; end
    if (busy_o) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual busy=1 required busy=0");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Reference model of one frame: op[1]=NEXT, op[0]=READ.
  task automatic frame(input logic [1:0] op, input logic [19:0] addr, input logic [7:0] data,
                       input logic [7:0] rdata, input int stall, input int dly,
                       input bit noack, input bit st, input bit wait_done);
    logic [7:0] b[4];
    int         n;
    txn_t       t;
    logic [3:0] nib;
    cfg_stall = stall; cfg_dly = dly; cfg_noack = noack; cfg_rdata = rdata;
    if (st) ref_err = 1'b0;
    nib  = op[1] ? 4'($urandom) : addr[19:16];
    b[0] = {op, 2'b00, nib};
    n    = 1;
    if (!op[1]) begin ref_addr = addr; b[1] = addr[15:8]; b[2] = addr[7:0]; n = 3; end
    if (!op[0]) begin b[n] = data; n++; end
    t.addr = ref_addr; t.we = !op[0]; t.data = data;
    t.stb_len = stall + 1;
    t.cyc_len = stall + 1 + (noack ? ACK_TIMEOUT : dly);
    wb_q.push_back(t);
    if (op[0] && !noack) rd_q.push_back(rdata);
    if (noack) ref_err = 1'b1;
    else       ref_addr = ref_addr + 20'd1;
    for (int i = 0; i < n; i++) send_byte(b[i], st && (i == 0));
    if (wait_done) wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", wb_cycle_o, 0);
    check("rst_stb", wb_strobe_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdv", rd_valid_o, 0);
    check("rst_addr", wb_addr_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame(2'b00, 20'h12345, 8'hA5, 8'h00, 0, 2, 0, 1, 1);
    frame(2'b10, 20'h0, 8'h5A, 8'h00, 0, 1, 0, 0, 1);       // expects 0x12346
    frame(2'b01, 20'h08000, 8'h00, 8'h3C, 0, 1, 0, 1, 1);
    frame(2'b11, 20'h0, 8'h00, 8'h7E, 0, 0, 0, 1, 1);
    frame(2'b01, 20'hFFFFF, 8'h00, 8'h99, 5, 1, 0, 1, 1);
    frame(2'b11, 20'h0, 8'h00, 8'h42, 0, 3, 0, 1, 1);       // wraps to 0x00000

    frame(2'b10, 20'h0, 8'h11, 8'h00, 0, 0, 1, 1, 1);       // no ack
    check("timeout_err", err_o, ref_err);
    pulse_start();
    ref_err = 1'b0;
    check("start_clears_err", err_o, ref_err);
    frame(2'b11, 20'h0, 8'h00, 8'hC3, 0, 0, 0, 0, 1);       // address unchanged by abort

    frame(2'b10, 20'h0, 8'h77, 8'h00, 0, 10, 0, 1, 0);
    @(posedge clk); #1;
    send_byte(8'h55, 1'b0);
    ref_err = 1'b1;
    check("overrun_err", err_o, ref_err);
    pulse_start();
    check("pending_err_held", err_o, ref_err);
    check("pending_busy", busy_o, 1);
    wait_idle();
    ref_err = 1'b0;
    check("pending_applied", err_o, ref_err);
    frame(2'b10, 20'h0, 8'h3E, 8'h00, 0, 1, 0, 0, 1);

    send_byte(8'h30, 1'b1);
    ref_err = 1'b1;
    send_byte(8'h01, 1'b0); send_byte(8'h23, 1'b0);
    send_byte(8'h45, 1'b0); send_byte(8'hA5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("invalid_busy", busy_o, 0);
    check("invalid_err", err_o, ref_err);
    pulse_start();
    ref_err = 1'b0;
    check("invalid_cleared", err_o, ref_err);

    frame(2'b11, 20'h0, 8'h00, 8'h00, 20, 0, 0, 1, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("areset_cyc", wb_cycle_o, 0);
    check("areset_stb", wb_strobe_o, 0);
    check("areset_busy", busy_o, 0);
    wb_q.delete(); rd_q.delete();
    ref_addr = '0; ref_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      frame(2'($urandom), 20'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 11) == 0),
            1'($urandom), 1);
      check("rand_err", err_o, ref_err);
    end

    check("wb_q_drained", wb_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
